// File: rtl/reg_in_irq.sv
// rtl/reg_in_irq.sv - input-port peripheral: synchronised input register, edge-detect W1C status, maskable irq
module reg_in_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  output logic             ready,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] in,
  output logic             irq
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_RISE_EN = 3'd1;
  localparam logic [2:0] A_FALL_EN = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_IRQ_EN  = 3'd4;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q,  status_d;
  logic [WIDTH-1:0] irq_en_q,  irq_en_d;
  logic             ready_q,   ready_d;
  logic [31:0]      rdata_q,   rdata_d;
  logic             irq_q,     irq_d;

  logic             fire;
  logic             is_wr;
  logic             is_rd;
  logic [2:0]       sel;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] status_clr;
  logic [31:0]      read_val;
  logic             unused_bits;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] val,
                                             input logic [WIDTH-1:0] msk);
    return (old & ~msk) | (val & msk);
  endfunction

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // A transaction executes on the edge that raises ready; ready itself blocks a repeat on the next edge.
  assign fire      = valid & ~ready_q;
  assign is_wr     = fire & (|wstrb);
  assign is_rd     = fire & ~(|wstrb);
  assign sel       = addr[4:2];
  assign lane_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign wmask     = lane_mask[WIDTH-1:0];
  assign wval      = wdata[WIDTH-1:0];

  assign unused_bits = ^{addr[31:5], addr[1:0], wdata, lane_mask};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= s;
    end
  end

  always_comb begin
    read_val = '0;
    case (sel)
      A_DATA:    read_val = zext(s);
      A_RISE_EN: read_val = zext(rise_en_q);
      A_FALL_EN: read_val = zext(fall_en_q);
      A_STATUS:  read_val = zext(status_q);
      A_IRQ_EN:  read_val = zext(irq_en_q);
      default:   read_val = '0;
    endcase
  end

  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_en_d   = irq_en_q;
    status_clr = '0;
    rdata_d    = rdata_q;
    ready_d    = fire;

    if (is_wr) begin
      case (sel)
        A_RISE_EN: rise_en_d  = merge(rise_en_q, wval, wmask);
        A_FALL_EN: fall_en_d  = merge(fall_en_q, wval, wmask);
        A_IRQ_EN:  irq_en_d   = merge(irq_en_q, wval, wmask);
        A_STATUS:  status_clr = wval & wmask;
        default:   ;
      endcase
    end

    if (is_rd) begin
      rdata_d = read_val;
    end

    // Set terms are OR-ed after the clear so a same-cycle edge survives the W1C.
    status_d = (status_q & ~status_clr) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d    = |(status_q & irq_en_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_en_q  <= irq_en_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_reg_in_irq.sv
// tb/tb_reg_in_irq.sv - scoreboard bench for reg_in_irq (WIDTH=8 and WIDTH=16 instances in lockstep)
module tb_reg_in_irq;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [7:0]  in8;
  logic [15:0] in16;
  logic        ready8, ready16, irq8, irq16;
  logic [31:0] rdata8, rdata16;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    bit          is_read;
    logic [31:0] exp8;
    logic [31:0] exp16;
  } txn_t;

  txn_t sb[$];

  always #5 clk = ~clk;

  reg_in_irq #(.WIDTH(8), .SYNC_STAGES(S)) u_dut8 (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready8), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata8), .in(in8), .irq(irq8)
  );

  reg_in_irq #(.WIDTH(16), .SYNC_STAGES(S)) u_dut16 (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready16), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata16), .in(in16), .irq(irq16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    txn_t t;
    if (resetn && ready8) begin
      if (sb.size() == 0) begin
        check_eq("spurious_ready", 32'(ready8), 32'd0);
      end else begin
        t = sb.pop_front();
        check_eq({t.tag, "_rdy16"}, 32'(ready16), 32'd1);
        if (t.is_read) begin
          check_eq({t.tag, "_w8"}, rdata8, t.exp8);
          check_eq({t.tag, "_w16"}, rdata16, t.exp16);
        end
      end
    end
  end

  task automatic bus(input string tag, input logic [2:0] idx, input logic [3:0] strb,
                     input logic [31:0] wd, input logic [31:0] e8, input logic [31:0] e16);
    txn_t t;
    bit   seen;
    seen = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    addr  = {27'd0, idx, 2'b00};
    wstrb = strb;
    wdata = wd;
    t.tag = tag; t.is_read = (strb == 4'd0); t.exp8 = e8; t.exp16 = e16;
    sb.push_back(t);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready8) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
    if (!seen) begin
      void'(sb.pop_front());
    end else begin
      @(posedge clk); #1;
      check_eq({tag, "_pulse"}, 32'(ready8), 32'd0);
    end
    valid = 1'b0;
    wstrb = 4'd0;
  endtask

  task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] e8, input logic [31:0] e16);
    bus(tag, idx, 4'd0, 32'd0, e8, e16);
  endtask

  task automatic wr(input string tag, input logic [2:0] idx, input logic [3:0] strb, input logic [31:0] wd);
    bus(tag, idx, strb, wd, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; valid = 1'b0; wstrb = 4'd0; addr = '0; wdata = '0;
    in8 = 8'h5A; in16 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready8", 32'(ready8), 32'd0);
    check_eq("rst_rdata8", rdata8, 32'd0);
    check_eq("rst_irq8", 32'(irq8), 32'd0);
    check_eq("rst_ready16", 32'(ready16), 32'd0);
    check_eq("rst_rdata16", rdata16, 32'd0);
    check_eq("rst_irq16", 32'(irq16), 32'd0);
    @(negedge clk) resetn = 1'b1;
    repeat (S + 1) @(posedge clk);

    for (int i = 0; i < 8; i++)
      rd($sformatf("rst_rd%0d", i), 3'(i), (i == 0) ? 32'h5A : 32'd0, 32'd0);

    // Readback one cycle too early still shows the old value; S cycles later shows the new one.
    in8 = 8'hA5;
    repeat (S - 1) @(posedge clk);
    rd("data_early", 3'd0, 32'h5A, 32'd0);
    rd("data_a5", 3'd0, 32'hA5, 32'd0);
    @(posedge clk); #1;
    in8 = 8'h3C;
    repeat (S) @(posedge clk);
    rd("data_exact", 3'd0, 32'h3C, 32'd0);
    wr("wr_data_ign", 3'd0, 4'hF, 32'hFFFF_FFFF);
    wr("wr_hole", 3'd6, 4'hF, 32'hFFFF_FFFF);
    rd("rd_data_ign", 3'd0, 32'h3C, 32'd0);
    rd("rd_hole", 3'd6, 32'd0, 32'd0);

    wr("rise_en1", 3'd1, 4'hF, 32'h01);
    wr("irq_en1", 3'd4, 4'hF, 32'h01);
    rd("rd_rise_en1", 3'd1, 32'h01, 32'h01);
    in8 = 8'h3D;
    repeat (S + 1) @(posedge clk);
    #1;
    check_eq("irq_not_yet", 32'(irq8), 32'd0);
    @(posedge clk); #1;
    check_eq("irq_rise", 32'(irq8), 32'd1);
    rd("status_rise", 3'd3, 32'h01, 32'd0);
    wr("w1c_bit0", 3'd3, 4'hF, 32'h01);
    check_eq("irq_cleared", 32'(irq8), 32'd0);
    rd("status_clr", 3'd3, 32'd0, 32'd0);

    in8 = 8'hBD;
    repeat (S + 2) @(posedge clk);
    wr("irq_en0", 3'd4, 4'hF, 32'd0);
    wr("fall_en80", 3'd2, 4'hF, 32'h80);
    in8 = 8'h3D;
    repeat (S + 3) @(posedge clk);
    #1;
    check_eq("irq_masked", 32'(irq8), 32'd0);
    rd("status_fall", 3'd3, 32'h80, 32'd0);
    wr("irq_en80", 3'd4, 4'hF, 32'h80);
    check_eq("irq_unmask", 32'(irq8), 32'd1);

    wr("rise_en4", 3'd1, 4'hF, 32'h04);
    wr("irq_en0b", 3'd4, 4'hF, 32'd0);
    in8 = 8'h39;
    repeat (S + 2) @(posedge clk);
    #1;
    in8 = 8'h3D;
    repeat (S) @(posedge clk);
    wr("w1c_race", 3'd3, 4'hF, 32'h04);
    rd("status_race", 3'd3, 32'h84, 32'd0);
    wr("w1c_all", 3'd3, 4'hF, 32'h84);
    rd("status_empty", 3'd3, 32'd0, 32'd0);

    wr("rise_en_b0", 3'd1, 4'h1, 32'hFFFF_FFFF);
    rd("rd_rise_b0", 3'd1, 32'h0000_00FF, 32'h0000_00FF);
    wr("rise_en_b1", 3'd1, 4'h2, 32'hFFFF_FFFF);
    rd("rd_rise_b1", 3'd1, 32'h0000_00FF, 32'h0000_FFFF);
    wr("irq_en_all", 3'd4, 4'hF, 32'hFFFF_FFFF);
    in16 = 16'h0100;
    repeat (S + 3) @(posedge clk);
    #1;
    check_eq("irq16_hi", 32'(irq16), 32'd1);
    check_eq("irq8_quiet", 32'(irq8), 32'd0);

    @(negedge clk);
    valid = 1'b1; addr = 32'h4; wstrb = 4'hF; wdata = 32'd0;
    @(posedge clk); #1;
    check_eq("abort_rdy_pre", 32'(ready16), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("abort_ready8", 32'(ready8), 32'd0);
    check_eq("abort_ready16", 32'(ready16), 32'd0);
    check_eq("abort_irq16", 32'(irq16), 32'd0);
    check_eq("abort_rdata16", rdata16, 32'd0);
    valid = 1'b0; wstrb = 4'd0;
    @(negedge clk) resetn = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
    check_eq("post_irq16", 32'(irq16), 32'd0);
    for (int i = 0; i < 8; i++)
      rd($sformatf("post_rd%0d", i), 3'(i), (i == 0) ? 32'h3D : 32'd0, (i == 0) ? 32'h0100 : 32'd0);

    repeat (2) @(posedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
